fan_tach_monitor: RTL and testbench
===================================

// Module: fan_tach_monitor
// PURPOSE
//  N-channel fan tachometer for the management subsystem; successor to the fixed two-instance tach pair.
//  Per fan: synchronised, glitch-filtered rising edges counted over a shared gate window, scaled to RPM.
//  Adds saturation, an update strobe and per-fan sticky stall alarms for the register interface / irq.
// PARAMETERS
//  NUM_FANS        2          number of tach channels
//  REFCLK_HZ       187500000  sys_clk frequency
//  GATE_DIV        4          gate windows per second; WINDOW = REFCLK_HZ/GATE_DIV cycles
//  PULSES_PER_REV  2          tach pulses per revolution; RPM_PER_EDGE = 60*GATE_DIV/PULSES_PER_REV
//  FILTER_CYCLES   4          consecutive equal samples required to accept a tach level change
//  STALL_WINDOWS   4          consecutive low-RPM windows before a stall alarm sets
// PORTS
//  sys_clk      in   1            management clock
//  rst_n        in   1            asynchronous active-low reset
//  fan_tach     in   NUM_FANS     raw tach inputs, asynchronous
//  min_rpm      in   16           stall threshold (0 disables stall detection)
//  alarm_clear  in   NUM_FANS     per-fan write-1 clear of stall_alarm
//  rpm          out  16*NUM_FANS  fan i speed at [16*i +: 16], RPM
//  rpm_update   out  1            1-cycle strobe: all rpm fields refreshed this cycle
//  stall_alarm  out  NUM_FANS     per-fan sticky stall flag
//  alarm_any    out  1            OR of stall_alarm, registered
// BEHAVIOUR
//  - Reset: rpm=0, rpm_update=0, stall_alarm=0, alarm_any=0; gate/edge/stall counters 0; filter state 0.
//  - Input path: 2-FF synchroniser, then filter; level accepted after FILTER_CYCLES identical samples.
//    Pulses shorter than FILTER_CYCLES are dropped. Edge = filtered 0->1 transition.
//  - Gate counter runs 0..WINDOW-1, wraps; terminal count (TC) common to all channels.
//  - Edge counter per fan, width clog2(WINDOW)+1, saturates at all-ones. On TC: count is latched and
//    cleared; an edge coincident with TC counts toward the new window.
//  - Cycle after TC: rpm_i = min(count_i*RPM_PER_EDGE, 16'hFFFF); rpm_update=1 that cycle only.
//  - Stall (evaluated in the same cycle as the rpm_update write, on the new value; min_rpm!=0):
//    rpm_i<min_rpm -> below_i++ (saturate at STALL_WINDOWS), else below_i=0.
//    below_i reaching STALL_WINDOWS sets stall_alarm[i]; stays set while condition persists.
//  - alarm_clear[i] clears stall_alarm[i] and below_i; set wins if set and clear coincide.
//  - min_rpm==0: below counters held at 0, no new alarms; existing alarms still need clear.
//  - alarm_any = |stall_alarm, one cycle later.
//  - Reset mid-window: partial counts discarded, first post-reset rpm_update after a full WINDOW.
//  - Latency tach edge -> counted: 2 + FILTER_CYCLES cycles.
// STRUCTURE
//  - Shared FanMonitorTypes.svh: rpm_t (16 bit), RPM_MAX constant.
//  - Sub-module fan_tach_channel: sync + filter + edge counter + stall counter for one fan;
//    generate-loop instantiated NUM_FANS times. Top holds gate counter, TC, rpm_update, alarm_any.
//  - RPM_PER_EDGE is an elaboration-time constant; multiply by constant, no dividers.
// TESTING (REFCLK_HZ=100000, GATE_DIV=100 -> WINDOW=1000, PPR=2 -> 3000 RPM/edge, FILTER=2, STALL=4)
//  1. Fan0 10 clean pulses/window (10 hi/10 lo), fan1 idle -> rpm0=30000, rpm1=0, rpm_update every 1000.
//  2. Fan0 21 then 22 pulses/window -> rpm0=63000, then 65535 (saturated).
//  3. Fan0 1-cycle glitches only, 50 per window -> rpm0=0.
//  4. min_rpm=6000, fan0 1 pulse/window -> stall_alarm[0] at 4th update, alarm_any one cycle later;
//     alarm_clear[0] with fan still slow -> clears, resets 4 windows later.
//  5. alarm_clear[0] on the setting cycle -> alarm stays 1; min_rpm=0, fan idle 10 windows -> no alarm.
//  6. rst_n low mid-window with 5 edges counted -> outputs 0 at once; next rpm_update 1000 cycles after
//     release, counting post-reset edges only.

Source files
------------

// File: rtl/fan_tach_monitor_pkg.sv
// Shared types and constants for the fan tachometer monitor.
package fan_tach_monitor_pkg;

  localparam int RPM_W = 16;

  typedef logic [RPM_W-1:0] rpm_t;

  localparam rpm_t RPM_MAX = 16'hFFFF;

endpackage

// File: rtl/fan_tach_channel.sv
// One tach channel: synchroniser, glitch filter, per-window edge counter,
// RPM scaling with saturation, and sticky stall detection.
module fan_tach_channel
  import fan_tach_monitor_pkg::*;
#(
  parameter int CNT_W         = 11,
  parameter int RPM_PER_EDGE  = 3000,
  parameter int FILTER_CYCLES = 4,
  parameter int STALL_WINDOWS = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        tach,
  input  logic        tc,
  input  logic [15:0] min_rpm,
  input  logic        alarm_clear,
  output logic [15:0] rpm,
  output logic        stall_alarm
);

  localparam int RUN_W   = $clog2(FILTER_CYCLES) + 1;
  localparam int BELOW_W = $clog2(STALL_WINDOWS + 1);
  localparam int PROD_RAW = CNT_W + $clog2(RPM_PER_EDGE + 1);
  localparam int PROD_W  = (PROD_RAW > RPM_W) ? PROD_RAW : RPM_W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [BELOW_W-1:0] BELOW_MAX = BELOW_W'(STALL_WINDOWS);

  function automatic rpm_t sat_rpm(input logic [PROD_W-1:0] prod);
    if (prod > PROD_W'(RPM_MAX)) return RPM_MAX;
    return prod[RPM_W-1:0];
  endfunction

  logic               sync_p0, sync_p1;
  logic               filt;
  logic [RUN_W-1:0]   run;
  logic               accept, edge_det;
  logic [CNT_W-1:0]   edge_cnt;
  rpm_t               rpm_new;
  logic [BELOW_W-1:0] below, below_nxt;
  logic               stall_set;

  // Stage p0/p1: two-flop synchroniser for the asynchronous tach input
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= tach;
      sync_p1 <= sync_p0;
    end
  end

  // Filter: a new level needs FILTER_CYCLES consecutive agreeing samples
  assign accept   = (sync_p1 != filt) && (run == RUN_W'(FILTER_CYCLES - 1));
  assign edge_det = accept && sync_p1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (sync_p1 == filt) begin
      run <= '0;
    end else if (accept) begin
      filt <= sync_p1;
      run  <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end

  // An edge landing on TC belongs to the window that is just starting
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      edge_cnt <= '0;
    else if (tc)
      edge_cnt <= CNT_W'(edge_det);
    else if (edge_det && edge_cnt != CNT_MAX)
      edge_cnt <= edge_cnt + 1'b1;
  end

  assign rpm_new = sat_rpm(PROD_W'(edge_cnt) * PROD_W'(RPM_PER_EDGE));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      rpm <= '0;
    else if (tc)
      rpm <= rpm_new;
  end

  // Stall judged on the value being written this TC, not the stale one
  always_comb begin
    below_nxt = below;
    if (min_rpm == '0)
      below_nxt = '0;
    else if (tc)
      below_nxt = (rpm_new < min_rpm) ?
                  ((below == BELOW_MAX) ? below : below + 1'b1) : '0;
    stall_set = tc && (min_rpm != '0) && (below_nxt == BELOW_MAX);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      below       <= '0;
      stall_alarm <= 1'b0;
    end else begin
      below <= (alarm_clear && !stall_set) ? '0 : below_nxt;
      if (stall_set)
        stall_alarm <= 1'b1;
      else if (alarm_clear)
        stall_alarm <= 1'b0;
    end
  end

endmodule

// File: rtl/fan_tach_monitor.sv
// N-channel fan tachometer: shared gate window, per-fan RPM and stall alarms.
module fan_tach_monitor
  import fan_tach_monitor_pkg::*;
#(
  parameter int NUM_FANS       = 2,
  parameter int REFCLK_HZ      = 187500000,
  parameter int GATE_DIV       = 4,
  parameter int PULSES_PER_REV = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int STALL_WINDOWS  = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic [NUM_FANS-1:0]       fan_tach,
  input  logic [15:0]               min_rpm,
  input  logic [NUM_FANS-1:0]       alarm_clear,
  output logic [RPM_W*NUM_FANS-1:0] rpm,
  output logic                      rpm_update,
  output logic [NUM_FANS-1:0]       stall_alarm,
  output logic                      alarm_any
);

  localparam int WINDOW       = REFCLK_HZ / GATE_DIV;
  localparam int GATE_W       = $clog2(WINDOW);
  localparam int CNT_W        = GATE_W + 1;
  localparam int RPM_PER_EDGE = 60 * GATE_DIV / PULSES_PER_REV;

  logic [GATE_W-1:0] gate_cnt;
  logic              tc;

  assign tc = (gate_cnt == GATE_W'(WINDOW - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      gate_cnt <= '0;
    else if (tc)
      gate_cnt <= '0;
    else
      gate_cnt <= gate_cnt + 1'b1;
  end

  // Stage p1: strobe and alarm summary follow TC / the alarm flops by one cycle
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rpm_update <= 1'b0;
      alarm_any  <= 1'b0;
    end else begin
      rpm_update <= tc;
      alarm_any  <= |stall_alarm;
    end
  end

  for (genvar i = 0; i < NUM_FANS; i++) begin : g_fan
    fan_tach_channel #(
      .CNT_W         (CNT_W),
      .RPM_PER_EDGE  (RPM_PER_EDGE),
      .FILTER_CYCLES (FILTER_CYCLES),
      .STALL_WINDOWS (STALL_WINDOWS)
    ) u_chan (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .tach        (fan_tach[i]),
      .tc          (tc),
      .min_rpm     (min_rpm),
      .alarm_clear (alarm_clear[i]),
      .rpm         (rpm[RPM_W*i +: RPM_W]),
      .stall_alarm (stall_alarm[i])
    );
  end

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed bench for fan_tach_monitor: WINDOW=1000 cycles, 3000 RPM per edge.
module tb_fan_tach_monitor;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [1:0]  fan_tach;
  logic [15:0] min_rpm;
  logic [1:0]  alarm_clear;
  logic [31:0] rpm;
  logic        rpm_update;
  logic [1:0]  stall_alarm;
  logic        alarm_any;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int upd_cyc = 0;
  int gap;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  fan_tach_monitor #(
    .NUM_FANS       (2),
    .REFCLK_HZ      (100000),
    .GATE_DIV       (100),
    .PULSES_PER_REV (2),
    .FILTER_CYCLES  (2),
    .STALL_WINDOWS  (4)
  ) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .fan_tach    (fan_tach),
    .min_rpm     (min_rpm),
    .alarm_clear (alarm_clear),
    .rpm         (rpm),
    .rpm_update  (rpm_update),
    .stall_alarm (stall_alarm),
    .alarm_any   (alarm_any)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_update(output int g);
    int n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (rpm_update !== 1'b1 && n < 1100);
    if (rpm_update !== 1'b1) chk("update_timeout", {31'd0, rpm_update}, 32'd1);
    g = cyc - upd_cyc;
    upd_cyc = cyc;
  endtask

  task automatic train(input int fan, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      fan_tach[fan] = 1'b1;
      repeat (hi) @(negedge sys_clk);
      fan_tach[fan] = 1'b0;
      repeat (lo) @(negedge sys_clk);
    end
  endtask

  task automatic run_window(input int n0, input int hi0, input int lo0,
                            input int n1, output int g);
    fork
      train(0, n0, hi0, lo0);
      train(1, n1, 10, 10);
    join
    wait_update(g);
  endtask

  task automatic pulse_clear(input int delay);
    repeat (delay) @(negedge sys_clk);
    alarm_clear[0] = 1'b1;
    @(negedge sys_clk);
    alarm_clear[0] = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    fan_tach    = 2'b00;
    min_rpm     = 16'd0;
    alarm_clear = 2'b00;
    repeat (3) @(negedge sys_clk);
    chk("reset_rpm",    rpm,                 32'd0);
    chk("reset_update", {31'd0, rpm_update}, 32'd0);
    chk("reset_stall",  {30'd0, stall_alarm}, 32'd0);
    chk("reset_any",    {31'd0, alarm_any},  32'd0);
    rst_n   = 1'b1;
    upd_cyc = cyc;

    // clean pulses, fan1 idle
    run_window(10, 10, 10, 0, gap);
    chk("t1_gap0", gap, 32'd1000);
    chk("t1_rpm0", {16'd0, rpm[15:0]},  32'd30000);
    chk("t1_rpm1", {16'd0, rpm[31:16]}, 32'd0);
    run_window(10, 10, 10, 0, gap);
    chk("t1_gap1", gap, 32'd1000);
    chk("t1_rpm0b", {16'd0, rpm[15:0]}, 32'd30000);

    // scaling and saturation
    run_window(21, 10, 10, 0, gap);
    chk("t2_rpm63000", {16'd0, rpm[15:0]}, 32'd63000);
    run_window(22, 10, 10, 0, gap);
    chk("t2_rpm_sat", {16'd0, rpm[15:0]}, 32'd65535);

    // one-cycle glitches are filtered out
    run_window(50, 1, 5, 0, gap);
    chk("t3_glitch_rpm", {16'd0, rpm[15:0]}, 32'd0);

    // stall sets on the 4th slow window, fan1 kept fast
    min_rpm = 16'd6000;
    for (int w = 1; w <= 4; w++) begin
      run_window(1, 10, 10, 10, gap);
      chk("t4_rpm0", {16'd0, rpm[15:0]}, 32'd3000);
      chk("t4_rpm1", {16'd0, rpm[31:16]}, 32'd30000);
      chk("t4_stall", {30'd0, stall_alarm}, (w < 4) ? 32'd0 : 32'd1);
    end
    chk("t4_any_lag", {31'd0, alarm_any}, 32'd0);
    @(negedge sys_clk);
    chk("t4_any", {31'd0, alarm_any}, 32'd1);

    // clear with fan still slow, alarm returns 4 windows later
    fork
      train(0, 1, 10, 10);
      train(1, 10, 10, 10);
      begin
        pulse_clear(300);
        chk("t4_cleared", {30'd0, stall_alarm}, 32'd0);
        @(negedge sys_clk);
        chk("t4_any_cleared", {31'd0, alarm_any}, 32'd0);
      end
    join
    wait_update(gap);
    chk("t4_after_clr1", {30'd0, stall_alarm}, 32'd0);
    for (int w = 2; w <= 4; w++) begin
      run_window(1, 10, 10, 10, gap);
      chk("t4_reassert", {30'd0, stall_alarm}, (w < 4) ? 32'd0 : 32'd1);
    end

    // clear coinciding with the setting cycle: set wins
    fork
      train(0, 1, 10, 10);
      train(1, 10, 10, 10);
      pulse_clear(200);
    join
    wait_update(gap);
    chk("t5_clr_u1", {30'd0, stall_alarm}, 32'd0);
    for (int w = 2; w <= 3; w++) begin
      run_window(1, 10, 10, 10, gap);
      chk("t5_clr_u", {30'd0, stall_alarm}, 32'd0);
    end
    fork
      train(0, 1, 10, 10);
      train(1, 10, 10, 10);
      begin
        repeat (999) @(negedge sys_clk);
        alarm_clear[0] = 1'b1;
      end
    join
    @(negedge sys_clk);
    alarm_clear[0] = 1'b0;
    chk("t5_tc_update", {31'd0, rpm_update}, 32'd1);
    chk("t5_set_wins", {30'd0, stall_alarm}, 32'd1);
    gap = cyc - upd_cyc;
    upd_cyc = cyc;
    chk("t5_tc_gap", gap, 32'd1000);

    // stall detection disabled: existing alarm held until cleared, no new ones
    min_rpm = 16'd0;
    for (int w = 1; w <= 10; w++) begin
      fork
        train(0, 0, 10, 10);
        if (w == 3) pulse_clear(100);
      join
      wait_update(gap);
      chk("t5_dis_rpm0", {16'd0, rpm[15:0]}, 32'd0);
      chk("t5_dis_stall", {30'd0, stall_alarm}, (w <= 2) ? 32'd1 : 32'd0);
    end

    // edge accepted exactly on TC counts toward the next window
    repeat (996) @(negedge sys_clk);
    fan_tach[0] = 1'b1;
    wait_update(gap);
    chk("t7_gap", gap, 32'd1000);
    chk("t7_old_window", {16'd0, rpm[15:0]}, 32'd0);
    repeat (6) @(negedge sys_clk);
    fan_tach[0] = 1'b0;
    wait_update(gap);
    chk("t7_new_window", {16'd0, rpm[15:0]}, 32'd3000);

    // reset mid-window discards partial count
    run_window(10, 10, 10, 0, gap);
    chk("t6_pre_rpm", {16'd0, rpm[15:0]}, 32'd30000);
    train(0, 5, 10, 10);
    repeat (100) @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rpm", rpm, 32'd0);
    chk("t6_rst_update", {31'd0, rpm_update}, 32'd0);
    chk("t6_rst_any", {31'd0, alarm_any}, 32'd0);
    repeat (3) @(negedge sys_clk);
    rst_n   = 1'b1;
    upd_cyc = cyc;
    run_window(3, 10, 10, 0, gap);
    chk("t6_gap", gap, 32'd1000);
    chk("t6_rpm", {16'd0, rpm[15:0]}, 32'd9000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
